// File: rtl/rom_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// rom_pkg : FSM state encoding and default widths shared by the ROM fetch path
// Rev 1.0
//------------------------------------------------------------------------------
package rom_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_ADDR_WIDTH = 8;
  localparam int DEFAULT_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
//------------------------------------------------------------------------------
// sync_fifo : single-clock FIFO with occupancy count, head zeroed when empty
// Rev 1.0
//------------------------------------------------------------------------------
module sync_fifo
  import rom_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr;
  logic [PW-1:0]    r_rd;
  logic [CW-1:0]    r_count;
  logic             w_pop;

  assign w_pop = pop && (r_count != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      r_mem[r_wr] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (push) begin
        r_wr <= r_wr + PW'(1);
      end
      if (w_pop) begin
        r_rd <= r_rd + PW'(1);
      end
      case ({push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign valid = (r_count != '0);
  assign head  = valid ? r_mem[r_rd] : '0;
  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/rom_fetch_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// rom_fetch_sequencer : credit-limited burst reader from a 1-cycle-latency ROM
// Rev 1.0
//------------------------------------------------------------------------------
module rom_fetch_sequencer
  import rom_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH-1:0] last_addr,
  output logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  error,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  fault
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int FW = ADDR_WIDTH + DATA_WIDTH;
  localparam logic [CW:0] CREDIT_MAX = (CW + 1)'(FIFO_DEPTH);

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_last;
  logic [ADDR_WIDTH-1:0] r_flight_addr;
  logic                  r_inflight;

  logic [CW-1:0]         w_count;
  logic                  w_fifo_valid;
  logic [FW-1:0]         w_head;
  logic [CW:0]           w_credit_used;
  logic                  w_credit_ok;
  logic                  w_err_cap;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_issue;
  logic                  w_done;

  // Words already buffered plus the one in the ROM pipe must leave room.
  assign w_credit_used = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
  assign w_credit_ok   = (w_credit_used < CREDIT_MAX);

  assign w_err_cap = r_inflight && error;
  assign w_push    = r_inflight && !error;
  assign w_pop     = w_fifo_valid && out_ready;
  assign w_issue   = (r_state == ST_FETCH) && w_credit_ok && !w_err_cap;

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data ({r_flight_addr, data}),
    .pop       (w_pop),
    .head      (w_head),
    .valid     (w_fifo_valid),
    .count     (w_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next = (start_addr > last_addr) ? ST_FAULT : ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (w_err_cap) begin
          w_next = ST_FAULT;
        end else if (w_issue && (r_addr == r_last)) begin
          w_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_err_cap) begin
          w_next = ST_FAULT;
        end else if (!r_inflight && !w_fifo_valid) begin
          w_next = ST_IDLE;
          w_done = 1'b1;
        end
      end
      ST_FAULT: begin
        if (start && !w_fifo_valid) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // The counter parks on the final address so an all-ones end never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr        <= '0;
      r_last        <= '0;
      r_flight_addr <= '0;
      r_inflight    <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_flight_addr <= r_addr;
      end
      if ((r_state == ST_IDLE) && start) begin
        r_addr <= start_addr;
        r_last <= last_addr;
      end else if (w_issue && (r_addr != r_last)) begin
        r_addr <= r_addr + ADDR_WIDTH'(1);
      end
    end
  end

  assign address   = r_addr;
  assign out_valid = w_fifo_valid;
  assign out_data  = w_head[DATA_WIDTH-1:0];
  assign out_addr  = w_head[FW-1:DATA_WIDTH];
  assign busy      = (r_state == ST_FETCH) || (r_state == ST_DRAIN);
  assign done      = w_done;
  assign fault     = (r_state == ST_FAULT);

endmodule
`default_nettype wire
